// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The slave modport is the loader's view; master is the host/memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 5
) ();
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a little-endian byte stream into instruction memory one 32-bit word at
// a time, holding the CPU stalled until a complete program has been written.
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  imem_loader_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       low_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              err_q;

  logic              idle_like;
  logic              start_ok;
  logic              byte_acc;
  logic              last_word;
  logic [ADDR_W:0]   count_sel;

  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign start_ok  = start && idle_like;
  assign byte_acc  = (state_q == LOAD) && bus.byte_valid;
  assign last_word = ({1'b0, addr_q} + (ADDR_W+1)'(1)) == count_q;
  // Zero and anything beyond the memory size both mean "fill the whole memory".
  assign count_sel = ((word_count == '0) || (word_count > DEPTH_W)) ? DEPTH_W : word_count;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    bus.byte_ready = 1'b0;
    bus.wr_en      = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    cpu_hold       = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
        if (byte_acc && byte_idx_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        bus.wr_en = 1'b1;
        busy      = 1'b1;
        state_d   = last_word ? DONE : LOAD;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      addr_q     <= '0;
      byte_idx_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      if (start_ok) begin
        count_q    <= count_sel;
        addr_q     <= '0;
        byte_idx_q <= '0;
        err_q      <= 1'b0;
      end else if (start) begin
        err_q <= 1'b1;
      end

      // The fourth byte goes straight into the write register with bytes 0..2.
      if (byte_acc) begin
        byte_idx_q <= byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          wr_data_q <= {bus.byte_in, low_q};
          wr_addr_q <= addr_q;
        end
      end

      if (state_q == WRITE && !last_word) addr_q <= addr_q + ADDR_W'(1);
    end
  end

  // NOTE: the partial-word buffer is deliberately not reset: the byte index is,
  // and every byte lane is overwritten before a word can be written.
  always_ff @(posedge clk) begin
    if (byte_acc) begin
      unique case (byte_idx_q)
        2'd0:    low_q[7:0]   <= bus.byte_in;
        2'd1:    low_q[15:8]  <= bus.byte_in;
        2'd2:    low_q[23:16] <= bus.byte_in;
        default: ;
      endcase
    end
  end

  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign err         = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as words are
// driven and matched against every wr_en strobe, including its latency.
module tb_imem_loader;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [ADDR_W:0] word_count = '0;
  logic            busy, done, cpu_hold, err;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .cpu_hold   (cpu_hold),
    .err        (err)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_errors = 0;
  wr_t sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: a write is due one cycle after every fourth accepted byte.
  int   bytes_seen = 0;
  logic exp_wr = 1'b0;
  always @(negedge clk) begin
    #1;
    if (bus.wr_en || exp_wr) begin
      check("wr_en_timing", bus.wr_en, exp_wr);
      if (bus.wr_en) begin
        check("write_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          wr_t e;
          e = sb.pop_front();
          check("wr_addr", bus.wr_addr, e.addr);
          check("wr_data", bus.wr_data, e.data);
        end
      end
    end
    if (!rst_n) begin
      exp_wr     = 1'b0;
      bytes_seen = 0;
    end else begin
      exp_wr = bus.byte_valid && bus.byte_ready && bytes_seen == 3;
      if (bus.byte_valid && bus.byte_ready) bytes_seen = (bytes_seen + 1) % 4;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic start_load(input int n);
    start      = 1'b1;
    word_count = (ADDR_W+1)'(n);
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    for (int k = 0; k < 20 && !bus.byte_ready; k++) @(negedge clk);
    if (!bus.byte_ready) check("byte_ready_timeout", bus.byte_ready, 1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [31:0] data, input int gap);
    logic [31:0] d;
    d = data;
    sb.push_back('{addr: addr, data: data});
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], (i % 2 == 1) ? gap : 0);
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 20 && !done; k++) @(negedge clk);
    check(tag, done, 1);
  endtask

  task automatic idle_noise(input string tag);
    bus.byte_in    = 8'hAA;
    bus.byte_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check(tag, bus.byte_ready, 0);
    end
    bus.byte_valid = 1'b0;
  endtask

  initial begin
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("rst_byte_ready", bus.byte_ready, 0);
    check("rst_wr_en",      bus.wr_en, 0);
    check("rst_wr_addr",    bus.wr_addr, 0);
    check("rst_wr_data",    bus.wr_data, 0);
    check("rst_busy",       busy, 0);
    check("rst_done",       done, 0);
    check("rst_err",        err, 0);
    check("rst_cpu_hold",   cpu_hold, 1);

    // Basic two-word load
    start_load(2);
    check("load_busy",       busy, 1);
    check("load_cpu_hold",   cpu_hold, 1);
    check("load_byte_ready", bus.byte_ready, 1);
    send_word(5'd0, 32'h0050_0013, 0);
    send_word(5'd1, 32'h0010_0093, 0);
    wait_done("basic_done");
    check("basic_cpu_hold", cpu_hold, 0);
    check("basic_busy",     busy, 0);
    check("hold_wr_addr",   bus.wr_addr, 1);
    check("hold_wr_data",   bus.wr_data, 32'h0010_0093);

    // Gapped byte stream, single word
    start_load(1);
    send_word(5'd0, 32'hDEAD_BEEF, 2);
    wait_done("gap_done");

    // Full depth via word_count = 0
    start_load(0);
    for (int w = 0; w < DEPTH; w++) send_word(ADDR_W'(w), $urandom, w % 3);
    wait_done("full_done");
    repeat (5) @(negedge clk);
    check("full_drained", sb.size(), 0);

    // start while busy flags err without disturbing the load
    start_load(1);
    sb.push_back('{addr: 5'd0, data: 32'h1122_3344});
    send_byte(8'h44, 0);
    send_byte(8'h33, 0);
    start_load(3);
    check("busy_start_err",  err, 1);
    check("busy_start_busy", busy, 1);
    send_byte(8'h22, 0);
    send_byte(8'h11, 0);
    wait_done("busy_start_done");
    check("err_sticky", err, 1);
    start_load(1);
    check("restart_err",  err, 0);
    check("restart_done", done, 0);
    check("restart_busy", busy, 1);
    send_word(5'd0, 32'hCAFE_F00D, 0);
    wait_done("restart_done2");

    // Bytes offered in DONE are ignored
    idle_noise("done_noise_ready");
    check("done_noise_done", done, 1);

    // Reset in the middle of a word
    start_load(2);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy",       busy, 0);
    check("midrst_cpu_hold",   cpu_hold, 1);
    check("midrst_byte_ready", bus.byte_ready, 0);
    check("midrst_wr_data",    bus.wr_data, 0);
    check("midrst_done",       done, 0);

    // Bytes offered in IDLE are ignored
    idle_noise("idle_noise_ready");
    check("idle_noise_busy", busy, 0);

    start_load(1);
    send_word(5'd0, 32'h0000_0513, 1);
    wait_done("post_rst_done");

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset, named clk and rst_n.
REQ-002 DEPTH SHALL be a parameter, default 32, giving the number of instruction words in the target instruction memory.
REQ-003 ADDR_W SHALL be a parameter, default 5, giving the instruction-memory word-address width, where 2^ADDR_W = DEPTH.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  request to begin a program load.
REQ-007 word_count  input  ADDR_W+1  number of words to load, sampled on an accepted start; 0 means DEPTH.
REQ-008 byte_in  input  8  program byte stream data.
REQ-009 byte_valid  input  1  byte_in holds a valid byte.
REQ-010 byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 wr_en  output  1  one-cycle write strobe to the instruction memory.
REQ-012 wr_addr  output  ADDR_W  word address for the write.
REQ-013 wr_data  output  32  assembled instruction word.
REQ-014 busy  output  1  a load is in progress.
REQ-015 done  output  1  sticky flag: load complete.
REQ-016 cpu_hold  output  1  holds the CPU core stalled while no complete program is present.
REQ-017 err  output  1  sticky flag: start was asserted while busy.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, WRITE and DONE, and the state SHALL be IDLE after reset.
REQ-019 IDLE/DONE -> LOAD on start=1: latch word_count (0 maps to DEPTH), clear the address counter, byte index, done and err.
REQ-020 In LOAD, byte_ready SHALL be 1 and a byte SHALL be accepted only on a cycle with byte_valid=1 and byte_ready=1.
REQ-021 Accepted bytes SHALL be packed little-endian into the assembled word: byte index 0 -> [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24].
REQ-022 The 2-bit byte index SHALL increment per accepted byte and wrap from 3 to 0.
REQ-023 On acceptance of byte index 3, the FSM SHALL enter WRITE.
REQ-024 In WRITE, for exactly one cycle: wr_en=1, wr_addr = the current address counter, wr_data = the assembled word, and byte_ready=0.
REQ-025 wr_en SHALL occur in the cycle immediately after the 4th byte handshake, giving a fixed latency of 1 cycle.
REQ-026 WRITE -> DONE if the number of words written equals the latched count; otherwise WRITE -> LOAD with the address counter incremented by 1.
REQ-027 The address SHALL never exceed DEPTH-1, so a count of DEPTH SHALL end after address DEPTH-1 is written, with no wrap.
REQ-028 In DONE: done=1, busy=0, byte_ready=0, and DONE SHALL be held until start.
REQ-029 busy SHALL be 1 exactly in LOAD and WRITE.
REQ-030 cpu_hold SHALL be 1 in IDLE, LOAD and WRITE, and 0 only in DONE.
REQ-031 A start during LOAD or WRITE SHALL be ignored for sequencing and SHALL set err=1, which stays set until the next accepted start.
REQ-032 A byte_valid presented outside LOAD SHALL not be accepted and SHALL have no effect.
REQ-033 wr_en SHALL be 0 in every state other than WRITE, and wr_addr/wr_data SHALL hold their last values when wr_en=0.
REQ-034 A partial word (fewer than 4 bytes) SHALL never be written.

Reset
REQ-035 rst_n=0 sampled on a clk edge SHALL force: state IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, cpu_hold=1.
REQ-036 A reset during LOAD or WRITE SHALL discard the partial word and the count, and no wr_en SHALL follow the reset.
REQ-037 Reset SHALL take priority over start and over byte handshakes in the same cycle.

Verification
REQ-038 Basic load: start with word_count=2, then bytes 13,00,50,00,93,00,10,00 -> wr_en at addr 0 with data 0x00500013, then at addr 1 with data 0x00100093; afterwards done=1 and cpu_hold=0.
REQ-039 Backpressure/gaps: byte_valid toggled 1,0,0,1,... across a 1-word load of 0xDEADBEEF -> exactly one wr_en, with data 0xDEADBEEF, one cycle after the last byte.
REQ-040 Full depth: word_count=0 with 128 bytes -> 32 writes to addresses 0..31 in order, no write to address 0 after 31, and done=1.
REQ-041 Start while busy: start pulsed after 2 bytes of a 1-word load -> err=1, the load continues, and a single write occurs; the next start from DONE clears err and done.
REQ-042 Mid-load reset: rst_n=0 after 3 bytes -> no wr_en, busy=0, cpu_hold=1; a new load then writes to address 0 with the correct data.
REQ-043 Idle noise: byte_valid=1 in IDLE and in DONE -> byte_ready=0 and no wr_en.
